alu_cmd_sequencer: RTL and testbench

Command front-end that drives the team's 32-bit ALU operation encoding. Accepts decoded-instruction fields plus operands over a valid/ready handshake and buffers them in a small FIFO. Maps the fields to a 3-bit ALU control code, executes one operation per cycle, and returns the result with status flags over a second valid/ready handshake. Sits between the instruction decode stage and writeback/branch logic.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_cmd_sequencer_if.sv | 35 +++
 rtl/alu_cmd_fifo.sv | 61 ++++++
 rtl/alu_cmd_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings, decode function and per-command control bundle for the
// ALU command sequencer.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_RSVD   = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // Decoded control carried with every command; the operands are added by the
  // top level, where their width is known.
  typedef struct packed {
    alu_ctrl_e control;
    logic      illegal;
  } alu_ctl_t;

  function automatic alu_ctl_t alu_decode(input logic [1:0] aluop,
                                          input logic [2:0] funct3,
                                          input logic       funct7b5,
                                          input logic       opb5);
    alu_ctl_t d;
    d.control = ALU_ADD;
    d.illegal = 1'b0;
    case (aluop)
      ALUOP_MEM:    d.control = ALU_ADD;
      ALUOP_BRANCH: d.control = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADDSUB: d.control = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_SLT:    d.control = ALU_SLT;
          F3_OR:     d.control = ALU_OR;
          F3_AND:    d.control = ALU_AND;
          default:   d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command-in and result-out handshake bundle of the ALU command sequencer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_aluop;
  logic [2:0]       in_funct3;
  logic             in_funct7b5;
  logic             in_opb5;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_alu_control;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;
  logic             out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_aluop, in_funct3, in_funct7b5, in_opb5, out_ready,
    output in_ready, out_valid, out_result, out_alu_control,
           out_zero, out_neg, out_carry, out_ovf, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_aluop, in_funct3, in_funct7b5, in_opb5, out_ready,
    input  in_ready, out_valid, out_result, out_alu_control,
           out_zero, out_neg, out_carry, out_ovf, out_err
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous DEPTH-entry FIFO of an arbitrary packed entry type; a push into a
// full FIFO is dropped even when a pop happens in the same cycle.
module alu_cmd_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [7:0],
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        wr_data,
  input  logic          pop,
  output entry_t        rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks keep all flops updating from pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count guards against reading stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command front-end: decodes at push, buffers in a FIFO, executes the head
// command into a held output register and counts completed result handshakes.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_sequencer_if.slave bus,
  output logic [15:0]        op_count
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_ctl_t         ctl;
  } cmd_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [2:0]       control;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
    logic             err;
  } res_t;

  cmd_t          push_cmd, head_cmd;
  logic          fifo_push, fifo_full, fifo_empty, load;
  logic [CW-1:0] fifo_count;
  logic [WIDTH:0] sum, diff;
  logic          ovf_add, ovf_sub;
  res_t          exec;
  res_t          res_q, res_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   op_count_q, op_count_d;

  always_comb begin
    push_cmd.a   = bus.in_a;
    push_cmd.b   = bus.in_b;
    push_cmd.ctl = alu_decode(bus.in_aluop, bus.in_funct3, bus.in_funct7b5, bus.in_opb5);
  end

  assign bus.in_ready = (fifo_count < CW'(DEPTH));
  assign fifo_push    = bus.in_valid && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (cmd_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (push_cmd),
    .pop     (load),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // One shared adder pair; SLT reuses the subtract's sign and overflow.
  always_comb begin
    sum     = {1'b0, head_cmd.a} + {1'b0, head_cmd.b};
    diff    = {1'b0, head_cmd.a} + {1'b0, ~head_cmd.b} + {{WIDTH{1'b0}}, 1'b1};
    ovf_add = (head_cmd.a[WIDTH-1] == head_cmd.b[WIDTH-1]) &&
              (sum[WIDTH-1] != head_cmd.a[WIDTH-1]);
    ovf_sub = (head_cmd.a[WIDTH-1] != head_cmd.b[WIDTH-1]) &&
              (diff[WIDTH-1] != head_cmd.a[WIDTH-1]);
    exec = '0;
    case (head_cmd.ctl.control)
      ALU_ADD: begin
        exec.result = sum[WIDTH-1:0];
        exec.carry  = sum[WIDTH];
        exec.ovf    = ovf_add;
      end
      ALU_SUB: begin
        exec.result = diff[WIDTH-1:0];
        exec.carry  = diff[WIDTH];
        exec.ovf    = ovf_sub;
      end
      ALU_AND: exec.result = head_cmd.a & head_cmd.b;
      ALU_OR:  exec.result = head_cmd.a | head_cmd.b;
      ALU_SLT: exec.result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
      default: exec.result = '0;
    endcase
    if (head_cmd.ctl.illegal) begin
      exec      = '0;
      exec.zero = 1'b1;
      exec.err  = 1'b1;
    end else begin
      exec.control = head_cmd.ctl.control;
      exec.zero    = (exec.result == '0);
      exec.neg     = exec.result[WIDTH-1];
    end
  end

  always_comb begin
    load        = !fifo_empty && (!out_valid_q || bus.out_ready);
    res_d       = res_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q + 16'(out_valid_q && bus.out_ready);
    if (load) begin
      res_d       = exec;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_result      = res_q.result;
  assign bus.out_alu_control = res_q.control;
  assign bus.out_zero        = res_q.zero;
  assign bus.out_neg         = res_q.neg;
  assign bus.out_carry       = res_q.carry;
  assign bus.out_ovf         = res_q.ovf;
  assign bus.out_err         = res_q.err;
  assign op_count            = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized and directed bench for alu_cmd_sequencer against a queue-based
// reference model evaluated with plain 64-bit arithmetic.
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] op_count;
  int          checks = 0;
  int          failures = 0;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // flags = {control[2:0], zero, neg, carry, ovf, err}
  typedef struct packed {
    logic [31:0] result;
    logic [7:0]  flags;
  } exp_t;

  exp_t        fifo_m[$];
  exp_t        out_m;
  bit          ov_m;
  logic [15:0] cnt_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_flags();
    return {bus.out_alu_control, bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf, bus.out_err};
  endfunction

  function automatic bit ovf32(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic exp_t model_exec(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op, input logic [2:0] f3,
                                      input bit f7, input bit opb5);
    exp_t            e;
    bit              ill;
    logic [2:0]      ctl;
    longint          sa, sb;
    longint unsigned ua, ub, u;
    logic [31:0]     r;
    bit              c, v;
    ill = 1'b0; ctl = 3'b000; r = 32'h0; c = 1'b0; v = 1'b0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'h0, a}; ub = {32'h0, b};
    case (op)
      2'b00: ctl = 3'b000;
      2'b01: ctl = 3'b001;
      2'b10: case (f3)
               3'b000:  ctl = (opb5 && f7) ? 3'b001 : 3'b000;
               3'b010:  ctl = 3'b101;
               3'b110:  ctl = 3'b011;
               3'b111:  ctl = 3'b010;
               default: ill = 1'b1;
             endcase
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e.result = 32'h0;
      e.flags  = {3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      return e;
    end
    case (ctl)
      3'b000: begin u = ua + ub; r = u[31:0]; c = u[32]; v = ovf32(sa + sb); end
      3'b001: begin r = a - b; c = (ua >= ub); v = ovf32(sa - sb); end
      3'b101: r = (sa < sb) ? 32'd1 : 32'd0;
      3'b011: r = a | b;
      default: r = a & b;
    endcase
    e.result = r;
    e.flags  = {ctl, r == 32'h0, r[31], c, v, 1'b0};
    return e;
  endfunction

  // One cycle: drive inputs just after a falling edge, check the DUT against the
  // model, advance the model across the rising edge, then wait for the next falling edge.
  task automatic step(input bit vld, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [2:0] f3, input bit f7,
                      input bit opb5, input bit ordy, output bit accepted);
    bit room;
    bus.in_valid = vld; bus.in_a = a; bus.in_b = b; bus.in_aluop = op;
    bus.in_funct3 = f3; bus.in_funct7b5 = f7; bus.in_opb5 = opb5; bus.out_ready = ordy;
    #1;
    room = (fifo_m.size() < DEPTH);
    check("in_ready", 64'(bus.in_ready), 64'(room));
    check("out_valid", 64'(bus.out_valid), 64'(ov_m));
    check("op_count", 64'(op_count), 64'(cnt_m));
    if (ov_m) begin
      check("result", 64'(bus.out_result), 64'(out_m.result));
      check("flags", 64'(dut_flags()), 64'(out_m.flags));
    end
    accepted = vld && bus.in_ready;
    if (ov_m && ordy) cnt_m++;
    if (fifo_m.size() > 0 && (!ov_m || ordy)) begin
      out_m = fifo_m.pop_front();
      ov_m  = 1'b1;
    end else if (ordy) begin
      ov_m = 1'b0;
    end
    if (vld && room) fifo_m.push_back(model_exec(a, b, op, f3, f7, opb5));
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    step(1'b0, 32'h0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b0, ordy, acc);
  endtask

  // Push one command into an idle pipeline and wait until its result is presented.
  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [2:0] f3, input bit f7, input bit opb5);
    bit acc;
    step(1'b1, a, b, op, f3, f7, opb5, 1'b1, acc);
    check("single_accept", 64'(acc), 64'd1);
    idle(1'b1);
    check("single_latency", 64'(bus.out_valid), 64'd1);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_0001;
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          acc_n;
    logic [15:0] base;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_aluop = '0;
    bus.in_funct3 = '0; bus.in_funct7b5 = 1'b0; bus.in_opb5 = 1'b0; bus.out_ready = 1'b0;
    fifo_m.delete(); ov_m = 1'b0; cnt_m = '0; out_m = '0;

    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_result", 64'(bus.out_result), 64'd0);
    check("rst_flags", 64'(dut_flags()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);

    // ADD 5+7
    single(32'd5, 32'd7, 2'b00, 3'b000, 1'b0, 1'b0);
    check("add_result", 64'(bus.out_result), 64'd12);
    check("add_control", 64'(bus.out_alu_control), 64'd0);
    check("add_zero", 64'(bus.out_zero), 64'd0);
    check("add_carry", 64'(bus.out_carry), 64'd0);
    idle(1'b1);
    check("add_op_count", 64'(op_count), 64'd1);

    // R-type SUB 3-5
    single(32'd3, 32'd5, 2'b10, 3'b000, 1'b1, 1'b1);
    check("sub_result", 64'(bus.out_result), 64'hFFFF_FFFE);
    check("sub_control", 64'(bus.out_alu_control), 64'd1);
    check("sub_neg", 64'(bus.out_neg), 64'd1);
    check("sub_carry", 64'(bus.out_carry), 64'd0);
    idle(1'b1);

    // signed overflow on ADD, then SLT -1 < 1
    single(32'h7FFF_FFFF, 32'd1, 2'b00, 3'b000, 1'b0, 1'b0);
    check("ovf_result", 64'(bus.out_result), 64'h8000_0000);
    check("ovf_ovf", 64'(bus.out_ovf), 64'd1);
    check("ovf_neg", 64'(bus.out_neg), 64'd1);
    idle(1'b1);
    single(32'hFFFF_FFFF, 32'd1, 2'b10, 3'b010, 1'b0, 1'b1);
    check("slt_result", 64'(bus.out_result), 64'd1);
    check("slt_control", 64'(bus.out_alu_control), 64'd5);
    idle(1'b1);

    // back-pressure: DEPTH+1 accepted, then drain in order
    base  = cnt_m;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'(100 + i), 32'(i), 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, acc);
      if (acc) acc_n++;
    end
    check("bp_accepted", 64'(acc_n), 64'(DEPTH + 1));
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    check("bp_op_count", 64'(op_count), 64'(base + 16'd3));

    // illegal commands
    single(32'h1234, 32'h5678, 2'b11, 3'b000, 1'b0, 1'b0);
    check("ill11_err", 64'(bus.out_err), 64'd1);
    check("ill11_result", 64'(bus.out_result), 64'd0);
    check("ill11_zero", 64'(bus.out_zero), 64'd1);
    check("ill11_control", 64'(bus.out_alu_control), 64'd0);
    idle(1'b1);
    single(32'h1234, 32'h5678, 2'b10, 3'b001, 1'b0, 1'b1);
    check("ill_f3_err", 64'(bus.out_err), 64'd1);
    check("ill_f3_result", 64'(bus.out_result), 64'd0);
    check("ill_f3_zero", 64'(bus.out_zero), 64'd1);
    idle(1'b1);

    // randomized traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_opnd(), rand_opnd(),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, acc);
    end
    for (int i = 0; i < 5; i++) idle(1'b1);

    // reset mid-stream with commands queued
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(i + 1), 32'd2, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, acc);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_op_count", 64'(op_count), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_result", 64'(bus.out_result), 64'd0);
    fifo_m.delete(); ov_m = 1'b0; cnt_m = '0; out_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle(1'b1);
    single(32'd20, 32'd22, 2'b00, 3'b000, 1'b0, 1'b0);
    check("post_rst_result", 64'(bus.out_result), 64'd42);
    idle(1'b1);
    check("post_rst_op_count", 64'(op_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
